cache_ctrl_fsm: RTL

Clocked controller for the 4-line, 4-word-per-block, direct-mapped, write-back, write-allocate data cache. It owns the tag, valid, dirty and data arrays and sequences lookup, dirty-block writeback and block refill. A one-transaction-at-a-time request/ready handshake faces the CPU, and a req/ack handshake faces main memory. It replaces the combinational, delay-driven cache model with a synthesizable FSM.

---
 rtl/cache_defs.sv | 43 ++++
 rtl/cache_ctrl_fsm_if.sv | 31 +++
 rtl/cache_line_store.sv | 45 ++++
 rtl/cache_ctrl_fsm.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cache_defs.sv
// rtl/cache_defs.sv - shared widths, state encoding and address field helpers for the data cache
package cache_defs;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int TAG_W      = 4;
  localparam int INDEX_W    = 2;
  localparam int WORD_SEL_W = 2;
  localparam int BLOCK_W    = 128;
  localparam int LINES      = 4;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  // Word address: the byte address with bits[1:0] dropped.
  typedef logic [ADDR_W-3:0] word_addr_t;

  function automatic logic [TAG_W-1:0] tag_of(input word_addr_t a);
    return a[7:4];
  endfunction

  function automatic logic [INDEX_W-1:0] index_of(input word_addr_t a);
    return a[3:2];
  endfunction

  function automatic logic [WORD_SEL_W-1:0] word_of(input word_addr_t a);
    return a[1:0];
  endfunction

  function automatic logic [DATA_W-1:0] get_word(input logic [BLOCK_W-1:0] blk,
                                                 input logic [WORD_SEL_W-1:0] w);
    return blk[w*DATA_W +: DATA_W];
  endfunction

  function automatic logic [BLOCK_W-1:0] put_word(input logic [BLOCK_W-1:0] blk,
                                                  input logic [WORD_SEL_W-1:0] w,
                                                  input logic [DATA_W-1:0] d);
    logic [BLOCK_W-1:0] r;
    r = blk;
    r[w*DATA_W +: DATA_W] = d;
    return r;
  endfunction

endpackage

// File: rtl/cache_ctrl_fsm_if.sv
// rtl/cache_ctrl_fsm_if.sv - CPU request/ready and memory req/ack signals of the cache controller
interface cache_ctrl_fsm_if;
  import cache_defs::*;

  logic                 cpu_req;
  logic                 cpu_rw;
  logic [ADDR_W-1:0]    cpu_addr;
  logic [DATA_W-1:0]    cpu_wdata;
  logic [DATA_W-1:0]    cpu_rdata;
  logic                 cpu_ready;
  logic                 cpu_hit;

  logic                 mem_req;
  logic                 mem_rw;
  logic [ADDR_W-1:0]    mem_addr;
  logic [BLOCK_W-1:0]   mem_wdata;
  logic [BLOCK_W-1:0]   mem_rdata;
  logic                 mem_ack;

  // master: the cache controller; slave: the CPU plus main memory around it
  modport master (
    input  cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, cpu_hit, mem_req, mem_rw, mem_addr, mem_wdata
  );

  modport slave (
    output cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, cpu_hit, mem_req, mem_rw, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_line_store.sv
// rtl/cache_line_store.sv - valid/dirty/tag/data arrays with combinational lookup and registered write
module cache_line_store
  import cache_defs::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  idx,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [BLOCK_W-1:0]  rd_block,
  input  logic                wr_en,
  input  logic                wr_valid,
  input  logic                wr_dirty,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [BLOCK_W-1:0]  wr_block
);

  logic [LINES-1:0]   valid;
  logic [LINES-1:0]   dirty;
  logic [TAG_W-1:0]   tag  [LINES];
  logic [BLOCK_W-1:0] data [LINES];

  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag   = tag[idx];
  assign rd_block = data[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else if (wr_en) begin
      valid[idx] <= wr_valid;
      dirty[idx] <= wr_dirty;
      tag[idx]   <= wr_tag;
      data[idx]  <= wr_block;
    end
  end

endmodule

// File: rtl/cache_ctrl_fsm.sv
// rtl/cache_ctrl_fsm.sv - direct-mapped write-back cache controller: lookup, writeback and refill sequencing
module cache_ctrl_fsm
  import cache_defs::*;
(
  input  logic               clk,
  input  logic               rst_n,
  cache_ctrl_fsm_if.master   bus
);

  state_t             state, state_nxt;
  logic               lat_rw;
  word_addr_t         lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic               miss_seen, miss_nxt;
  logic               ready_q, ready_nxt;
  logic               hit_q, hit_nxt;
  logic [DATA_W-1:0]  rdata_q, rdata_nxt;
  logic               take;

  logic               rd_valid, rd_dirty, wr_en, wr_valid, wr_dirty;
  logic [TAG_W-1:0]   rd_tag, wr_tag;
  logic [BLOCK_W-1:0] rd_block, wr_block;
  logic [INDEX_W-1:0] idx;
  logic               lookup_hit;

  assign idx        = index_of(lat_addr);
  assign lookup_hit = rd_valid && (rd_tag == tag_of(lat_addr));

  cache_line_store u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .idx      (idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_block (rd_block),
    .wr_en    (wr_en),
    .wr_valid (wr_valid),
    .wr_dirty (wr_dirty),
    .wr_tag   (wr_tag),
    .wr_block (wr_block)
  );

  // Memory side decodes purely from state so reset drops mem_req without a clock edge.
  assign bus.mem_req   = (state == WRITEBACK) || (state == ALLOCATE);
  assign bus.mem_rw    = (state == WRITEBACK);
  assign bus.mem_addr  = (state == WRITEBACK) ? {rd_tag, idx, 4'b0000} :
                         (state == ALLOCATE)  ? {lat_addr[7:2], 4'b0000} : '0;
  assign bus.mem_wdata = (state == WRITEBACK) ? rd_block : '0;

  assign bus.cpu_ready = ready_q;
  assign bus.cpu_hit   = hit_q;
  assign bus.cpu_rdata = rdata_q;

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    miss_nxt  = miss_seen;
    ready_nxt = 1'b0;
    hit_nxt   = hit_q;
    rdata_nxt = rdata_q;
    wr_en     = 1'b0;
    wr_valid  = rd_valid;
    wr_dirty  = rd_dirty;
    wr_tag    = rd_tag;
    wr_block  = rd_block;
    unique case (state)
      IDLE: begin
        if (bus.cpu_req) begin
          take      = 1'b1;
          state_nxt = COMPARE;
        end
      end
      COMPARE: begin
        if (lookup_hit) begin
          ready_nxt = 1'b1;
          hit_nxt   = !miss_seen;
          state_nxt = IDLE;
          if (lat_rw) begin
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
            wr_block = put_word(rd_block, word_of(lat_addr), lat_wdata);
          end else begin
            rdata_nxt = get_word(rd_block, word_of(lat_addr));
          end
        end else begin
          miss_nxt  = 1'b1;
          state_nxt = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (bus.mem_ack) begin
          wr_en     = 1'b1;
          wr_valid  = 1'b0;
          wr_dirty  = 1'b0;
          state_nxt = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (bus.mem_ack) begin
          wr_en     = 1'b1;
          wr_valid  = 1'b1;
          wr_dirty  = 1'b0;
          wr_tag    = tag_of(lat_addr);
          wr_block  = bus.mem_rdata;
          state_nxt = COMPARE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_rw    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      miss_seen <= 1'b0;
      ready_q   <= 1'b0;
      hit_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= ready_nxt;
      hit_q   <= hit_nxt;
      rdata_q <= rdata_nxt;
      if (take) begin
        lat_rw    <= bus.cpu_rw;
        lat_addr  <= bus.cpu_addr[ADDR_W-1:2];
        lat_wdata <= bus.cpu_wdata;
        miss_seen <= 1'b0;
      end else begin
        miss_seen <= miss_nxt;
      end
    end
  end

endmodule
